// File: rtl/uart_serializer.sv
// uart_serializer
// Frame-level UART transmitter. One word is accepted per valid/ready
// handshake and sent LSB-first as start, data, optional parity and stop bits.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   data_tx      word to send, sampled only on the accepting edge
//   valid_in     data_tx is valid
//   ready_out    block can accept a word this cycle (IDLE)
//   uart_out     registered serial line, idle high
//   busy         a frame is in progress
//   baud_trigger one-cycle pulse on the last clock of every bit period
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | line high, waiting for a handshake
// S_START  | start bit (low)
// S_DATA   | data bits, shift register bit 0 on the line
// S_PARITY | parity bit (only when parity is enabled)
// S_STOP   | stop bit(s), high
module uart_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_N-1:0] data_tx,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              uart_out,
  output logic              busy,
  output logic              baud_trigger
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $fatal(1, "uart_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (BITS_N < 5 || BITS_N > 9) begin : g_bad_bits
    $fatal(1, "uart_serializer: BITS_N must be 5..9");
  end
  if (PARITY_TYPE < 0 || PARITY_TYPE > 2) begin : g_bad_parity
    $fatal(1, "uart_serializer: PARITY_TYPE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "uart_serializer: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // One extra index bit lets the same counter walk the two stop bits.
  localparam int IDX_W = $clog2(BITS_N) + ((STOP_BITS == 2) ? 1 : 0);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(BITS_N - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [BITS_N-1:0] shift_reg, shift_nxt;
  logic              parity_bit, parity_nxt;
  logic              line_nxt;
  logic              accept;
  logic              bit_end;

  assign ready_out    = (state == S_IDLE);
  assign busy         = !ready_out;
  assign accept       = valid_in && ready_out;
  assign bit_end      = (state != S_IDLE) && (baud_cnt == CNT_LAST);
  assign baud_trigger = bit_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      uart_out   <= 1'b1;
    end else begin
      state      <= state_nxt;
      bit_idx    <= bit_idx_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      // Line is registered from the current state, so it trails the state
      // by one clock and the start bit appears one edge after acceptance.
      uart_out   <= line_nxt;
      if (state == S_IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    parity_nxt  = parity_bit;
    line_nxt    = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) begin
          shift_nxt   = data_tx;
          parity_nxt  = (PARITY_TYPE == 1) ? ~^data_tx : ^data_tx;
          bit_idx_nxt = '0;
          state_nxt   = S_START;
        end
      end
      S_START: begin
        line_nxt = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        line_nxt = shift_reg[0];
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        line_nxt = parity_bit;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        line_nxt = 1'b1;
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = S_IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_serializer.sv
module tb_uart_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data_tx;
  logic       valid[4];
  logic       ready[4];
  logic       uart[4];
  logic       busy[4];
  logic       trig[4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  uart_serializer #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .data_tx(data_tx), .valid_in(valid[0]), .ready_out(ready[0]),
    .uart_out(uart[0]), .busy(busy[0]), .baud_trigger(trig[0]));
  uart_serializer #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .data_tx(data_tx), .valid_in(valid[1]), .ready_out(ready[1]),
    .uart_out(uart[1]), .busy(busy[1]), .baud_trigger(trig[1]));
  uart_serializer #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst(rst), .data_tx(data_tx), .valid_in(valid[2]), .ready_out(ready[2]),
    .uart_out(uart[2]), .busy(busy[2]), .baud_trigger(trig[2]));
  uart_serializer #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .data_tx(data_tx), .valid_in(valid[3]), .ready_out(ready[3]),
    .uart_out(uart[3]), .busy(busy[3]), .baud_trigger(trig[3]));

  task automatic test_reset();
    rst = 1'b0;
    data_tx = 8'h00;
    for (int k = 0; k < 4; k++) valid[k] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (uart[k] !== 1'b1 || ready[k] !== 1'b1 || busy[k] !== 1'b0 || trig[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values inst %0d: uart=%b ready=%b busy=%b trig=%b, need 1 1 0 0",
                 k, uart[k], ready[k], busy[k], trig[k]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    int bad_uart = 0, bad_ready = 0, bad_busy = 0, trig_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (uart[k] !== 1'b1) bad_uart++;
        if (ready[k] !== 1'b1) bad_ready++;
        if (busy[k] !== 1'b0) bad_busy++;
        if (trig[k] !== 1'b0) trig_cnt++;
      end
    end
    checks++;
    if (bad_uart != 0) begin errors++; $display("FAIL idle_uart: %0d low samples, need 0", bad_uart); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL idle_ready: %0d not-ready samples, need 0", bad_ready); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL idle_busy: %0d busy samples, need 0", bad_busy); end
    checks++;
    if (trig_cnt != 0) begin errors++; $display("FAIL idle_trigger: %0d pulses, need 0", trig_cnt); end
  endtask

  // Sends one word on instance k and checks the whole frame. nbits is the
  // frame length in bit periods; exp holds the line bits, bit 0 sent first.
  task automatic run_frame(input int k, input logic [7:0] d, input int nbits,
                           input logic [15:0] exp, input string name);
    logic [15:0] seen = '0;
    int glitch = 0, ready_low = 0, busy_cnt = 0, trig_cnt = 0;
    logic lat0, lat1 = 1'b1;
    @(negedge clk);
    data_tx = d;
    valid[k] = 1'b1;
    @(negedge clk);
    valid[k] = 1'b0;
    lat0 = uart[k];
    for (int s = 0; s <= nbits * 4 + 2; s++) begin
      if (s > 0) @(negedge clk);
      if (ready[k] === 1'b0) ready_low++;
      if (busy[k] === 1'b1) busy_cnt++;
      if (trig[k] === 1'b1) trig_cnt++;
      if (s == 1) lat1 = uart[k];
      if (s >= 1 && s <= nbits * 4) begin
        if ((s - 1) % 4 == 0) seen[(s - 1) / 4] = uart[k];
        else if (uart[k] !== seen[(s - 1) / 4]) glitch++;
      end
    end
    checks++;
    if (lat0 !== 1'b1 || lat1 !== 1'b0) begin
      errors++;
      $display("FAIL %s latency: line after accept=%b next=%b, need 1 0", name, lat0, lat1);
    end
    checks++;
    if (seen !== exp || glitch != 0) begin
      errors++;
      $display("FAIL %s bits: got %h (glitches %0d), need %h", name, seen, glitch, exp);
    end
    checks++;
    if (ready_low != nbits * 4) begin
      errors++;
      $display("FAIL %s ready_low: %0d cycles, need %0d", name, ready_low, nbits * 4);
    end
    checks++;
    if (busy_cnt != nbits * 4) begin
      errors++;
      $display("FAIL %s busy: %0d cycles, need %0d", name, busy_cnt, nbits * 4);
    end
    checks++;
    if (trig_cnt != nbits) begin
      errors++;
      $display("FAIL %s baud_trigger: %0d pulses, need %0d", name, trig_cnt, nbits);
    end
    checks++;
    if (ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after: %b, need 1", name, ready[k]);
    end
  endtask

  task automatic test_8n1();
    run_frame(0, 8'hA5, 10, {1'b1, 8'hA5, 1'b0}, "8n1_a5");
  endtask

  task automatic test_parity();
    run_frame(1, 8'hA5, 11, {1'b1, 1'b0, 8'hA5, 1'b0}, "even_a5");
    run_frame(1, 8'h07, 11, {1'b1, 1'b1, 8'h07, 1'b0}, "even_07");
    run_frame(2, 8'hA5, 11, {1'b1, 1'b1, 8'hA5, 1'b0}, "odd_a5");
  endtask

  task automatic test_back_to_back();
    logic line[90];
    logic rdy[90];
    logic [15:0] f1 = '0, f2 = '0;
    int glitch = 0, ready_hi = 0;
    @(negedge clk);
    data_tx = 8'h55;
    valid[0] = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 90; s++) begin
      if (s > 0) @(negedge clk);
      line[s] = uart[0];
      rdy[s] = ready[0];
      if (s == 5) data_tx = 8'h99;
      if (s == 30) data_tx = 8'h0F;
      if (s == 41) valid[0] = 1'b0;
    end
    for (int s = 1; s <= 40; s++) begin
      if ((s - 1) % 4 == 0) f1[(s - 1) / 4] = line[s];
      else if (line[s] !== f1[(s - 1) / 4]) glitch++;
    end
    for (int s = 42; s <= 81; s++) begin
      if ((s - 42) % 4 == 0) f2[(s - 42) / 4] = line[s];
      else if (line[s] !== f2[(s - 42) / 4]) glitch++;
    end
    for (int s = 0; s <= 80; s++) if (rdy[s] === 1'b1) ready_hi++;
    checks++;
    if (line[0] !== 1'b1 || line[1] !== 1'b0 || line[41] !== 1'b1 || line[42] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_spacing: line[0,1,41,42]=%b%b%b%b, need 1010",
               line[0], line[1], line[41], line[42]);
    end
    checks++;
    if (f1 !== 16'({1'b1, 8'h55, 1'b0})) begin
      errors++;
      $display("FAIL b2b_first: got %h, need %h", f1, 16'({1'b1, 8'h55, 1'b0}));
    end
    checks++;
    if (f2 !== 16'({1'b1, 8'h0F, 1'b0})) begin
      errors++;
      $display("FAIL b2b_second: got %h, need %h", f2, 16'({1'b1, 8'h0F, 1'b0}));
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL b2b_glitch: %0d mid-bit changes, need 0", glitch);
    end
    checks++;
    if (ready_hi != 1 || rdy[40] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_gap: %0d ready cycles (ready[40]=%b), need 1 at 40", ready_hi, rdy[40]);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stop2();
    run_frame(3, 8'h00, 11, {2'b11, 8'h00, 1'b0}, "stop2_00");
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    // Reset during the start bit: line must go high without a clock edge.
    @(negedge clk);
    data_tx = 8'h00;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (uart[0] !== 1'b0) begin errors++; $display("FAIL rst_start_pre: uart=%b, need 0", uart[0]); end
    rst = 1'b0;
    #1;
    checks++;
    if (uart[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_start_async: uart=%b busy=%b ready=%b, need 1 0 1", uart[0], busy[0], ready[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    // Reset during data bit 3 of 0xFF.
    @(negedge clk);
    data_tx = 8'hFF;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (18) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: busy=%b, need 1", busy[0]); end
    rst = 1'b0;
    #1;
    checks++;
    if (uart[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1 || trig[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: uart=%b busy=%b ready=%b trig=%b, need 1 0 1 0",
               uart[0], busy[0], ready[0], trig[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (uart[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_no_resume: %0d active samples, need 0", bad); end
    run_frame(0, 8'h3C, 10, {1'b1, 8'h3C, 1'b0}, "after_rst_3c");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_stop2();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
